spi_tx_fifo: RTL and testbench
==============================

// Module: spi_tx_fifo
// PURPOSE
//  Data-supply FIFO answering the fifo_req_data / fifo_din / fifo_din_valid / fifo_empty pull
//  interface of spi_master and spi_slave. Host logic writes bytes in; the SPI block pulls one
//  word per request. One instance per SPI endpoint (master + each slave) in the SPI subsystem.
// PARAMETERS
//  data_width_g     8   width of each stored word (matches SPI word width)
//  depth_log2_g     4   log2 of FIFO depth (default depth = 16 words)
//  almost_full_g    14  used-word count at or above which almost_full asserts (0 < value <= depth)
// PORTS
//  clk             in   1                   system clock, all logic on rising edge
//  rst             in   1                   synchronous reset, active-high
//  wr_en           in   1                   write request, host side
//  wr_data         in   data_width_g        word to write
//  flush           in   1                   synchronous clear of contents (pointers/count only)
//  full            out  1                   FIFO holds 2**depth_log2_g words
//  almost_full     out  1                   used >= almost_full_g
//  overflow        out  1                   1-cycle pulse: write dropped
//  underflow       out  1                   1-cycle pulse: request while empty
//  used            out  depth_log2_g+1      registered count of stored words
//  fifo_req_data   in   1                   read request from SPI block
//  fifo_din        out  data_width_g        read data to SPI block
//  fifo_din_valid  out  1                   fifo_din valid, 1-cycle pulse
//  fifo_empty      out  1                   no words stored
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): rd/wr pointers=0, used=0, fifo_empty=1, full=0,
//    almost_full=0, overflow=0, underflow=0, fifo_din=0, fifo_din_valid=0. Memory not cleared.
//    Reset mid-transfer: a pending read is abandoned; fifo_din_valid is 0 the cycle after.
//  - Storage: 2**depth_log2_g x data_width_g array. Pointers are depth_log2_g bits and wrap
//    modulo depth. All flags are registered and derived from next-state used.
//  - Read: fifo_req_data=1 at edge N with fifo_empty=0 -> fifo_din = mem[rd_ptr] and
//    fifo_din_valid=1 after edge N (valid during cycle N+1, 1-cycle latency), rd_ptr++, used--.
//    fifo_din holds its last value when valid=0. Back-to-back requests give one word per cycle.
//  - Read while fifo_empty=1: ignored. No pointer change, valid stays 0, underflow pulses 1 cycle.
//  - Write: wr_en=1 with full=0 -> mem[wr_ptr]=wr_data, wr_ptr++, used++.
//  - Write while full=1: accepted only if a valid read occurs the same cycle (used unchanged).
//    Otherwise dropped, overflow pulses 1 cycle.
//  - Simultaneous valid read and write: both take effect, used unchanged. When fifo_empty=1,
//    write+req in the same cycle: the write is stored, the req counts as an underflow. There is
//    no fall-through: the written word is first readable the cycle after fifo_empty drops.
//  - Flag timing: a write at edge N clears fifo_empty after edge N. The read that takes the last
//    word sets fifo_empty after the same edge that raises fifo_din_valid.
//  - flush=1: pointers=0, used=0, fifo_empty=1, full=0. Concurrent wr_en/fifo_req_data are
//    ignored, and neither overflow nor underflow pulses. rst has priority over flush.
//  - Invariants: full and fifo_empty are never both 1. used <= 2**depth_log2_g.
// TESTING
//  1 Reset: hold rst 2 cycles -> fifo_empty=1, used=0, fifo_din_valid=0, all pulses 0.
//  2 Write 0x11,0x22,0x33, then 3 back-to-back reqs -> fifo_din_valid high 3 cycles,
//    fifo_din 0x11,0x22,0x33, each 1 cycle after its req; fifo_empty=1 after the 3rd read.
//  3 Write 16 words 0x00..0x0F -> full=1, almost_full=1 from used=14. A 17th write (0xAA) ->
//    overflow pulse, used stays 16. Drain 16 words -> data 0x00..0x0F, 0xAA never appears.
//  4 Full FIFO, wr_en=1 (0x55) + fifo_req_data=1 same cycle -> valid read of oldest word, write
//    accepted, used=16. 0x55 emerges 16th after draining. Repeat on an empty FIFO -> underflow pulse.
//  5 Wrap: 40 interleaved writes/reads of an incrementing pattern 0x00..0x27 -> read order
//    exact, no overflow/underflow pulses.
//  6 Write 5 words, issue req, assert rst the next cycle -> fifo_din_valid=0 after rst,
//    used=0, fifo_empty=1. Repeat with flush -> same result.

Source files
------------

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: host-written word FIFO that feeds the request/valid pull interface of an SPI endpoint.
// Reads have one cycle of latency. Every flag is registered and derived from the next-state word count.
module spi_tx_fifo #(
  parameter int data_width_g  = 8,
  parameter int depth_log2_g  = 4,
  parameter int almost_full_g = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [data_width_g-1:0] wr_data,
  input  logic                    flush,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow,
  output logic                    underflow,
  output logic [depth_log2_g:0]   used,
  input  logic                    fifo_req_data,
  output logic [data_width_g-1:0] fifo_din,
  output logic                    fifo_din_valid,
  output logic                    fifo_empty
);

  localparam int depth_c = 1 << depth_log2_g;
  localparam logic [depth_log2_g:0]   depth_cnt_c = (depth_log2_g+1)'(depth_c);
  localparam logic [depth_log2_g:0]   af_cnt_c    = (depth_log2_g+1)'(almost_full_g);
  localparam logic [depth_log2_g:0]   cnt_one_c   = (depth_log2_g+1)'(1);
  localparam logic [depth_log2_g-1:0] ptr_one_c   = depth_log2_g'(1);

  logic [data_width_g-1:0] mem_r [depth_c];
  logic [depth_log2_g-1:0] rd_ptr_r;
  logic [depth_log2_g-1:0] wr_ptr_r;
  logic [depth_log2_g:0]   used_r;
  logic [depth_log2_g:0]   used_nxt_s;
  logic [data_width_g-1:0] dout_r;
  logic                    valid_r;
  logic                    empty_r;
  logic                    full_r;
  logic                    af_r;
  logic                    ov_r;
  logic                    un_r;
  logic                    rd_ok_s;
  logic                    wr_ok_s;
  logic                    ov_s;
  logic                    un_s;

  // Qualify requests against the current flags and compute the next word count.
  // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok_s    = 1'b0;
    wr_ok_s    = 1'b0;
    ov_s       = 1'b0;
    un_s       = 1'b0;
    used_nxt_s = used_r;
    if (flush) begin
      used_nxt_s = '0;
    end else begin
      rd_ok_s = fifo_req_data & ~empty_r;
      wr_ok_s = wr_en & (~full_r | rd_ok_s);
      ov_s    = wr_en & full_r & ~rd_ok_s;
      un_s    = fifo_req_data & empty_r;
      if (wr_ok_s && !rd_ok_s) begin
        used_nxt_s = used_r + cnt_one_c;
      end else if (rd_ok_s && !wr_ok_s) begin
        used_nxt_s = used_r - cnt_one_c;
      end else begin
        used_nxt_s = used_r;
      end
    end
  end

  // Storage array. Reset does not clear it.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !rst) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, read data, count and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      used_r   <= '0;
      dout_r   <= '0;
      valid_r  <= 1'b0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      af_r     <= 1'b0;
      ov_r     <= 1'b0;
      un_r     <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
      end else begin
        if (rd_ok_s) begin
          rd_ptr_r <= rd_ptr_r + ptr_one_c;
        end
        if (wr_ok_s) begin
          wr_ptr_r <= wr_ptr_r + ptr_one_c;
        end
      end
      // fifo_din keeps its last word whenever no read is granted.
      if (rd_ok_s) begin
        dout_r  <= mem_r[rd_ptr_r];
        valid_r <= 1'b1;
      end else begin
        valid_r <= 1'b0;
      end
      used_r  <= used_nxt_s;
      empty_r <= (used_nxt_s == '0);
      full_r  <= (used_nxt_s == depth_cnt_c);
      af_r    <= (used_nxt_s >= af_cnt_c);
      ov_r    <= ov_s;
      un_r    <= un_s;
    end
  end

  assign full           = full_r;
  assign almost_full    = af_r;
  assign overflow       = ov_r;
  assign underflow      = un_r;
  assign used           = used_r;
  assign fifo_din       = dout_r;
  assign fifo_din_valid = valid_r;
  assign fifo_empty     = empty_r;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Bench for spi_tx_fifo: directed scenarios followed by random traffic.
// Every cycle is checked against a queue-based reference model.
module tb_spi_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       fifo_req_data = 1'b0;
  logic       full, almost_full, overflow, underflow, fifo_din_valid, fifo_empty;
  logic [4:0] used;
  logic [7:0] fifo_din;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  byte unsigned q[$];
  logic [7:0]   m_dout = 8'h00;
  bit           m_valid, m_ov, m_un;

  spi_tx_fifo #(.data_width_g(8), .depth_log2_g(4), .almost_full_g(14)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .almost_full(almost_full), .overflow(overflow), .underflow(underflow),
    .used(used), .fifo_req_data(fifo_req_data), .fifo_din(fifo_din),
    .fifo_din_valid(fifo_din_valid), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the sampled inputs of one clock edge to the reference model.
  task automatic model_edge();
    bit was_empty, was_full, rd;
    if (rst) begin
      q.delete();
      m_dout = 8'h00; m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else if (flush) begin
      q.delete();
      m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == 16);
      rd   = fifo_req_data && !was_empty;
      m_un = fifo_req_data && was_empty;
      if (rd) begin
        m_dout  = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      m_ov = wr_en && was_full && !rd;
      if (wr_en && (!was_full || rd)) q.push_back(wr_data);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".valid"}, 32'(fifo_din_valid), 32'(m_valid));
    chk({tag, ".din"}, 32'(fifo_din), 32'(m_dout));
    chk({tag, ".used"}, 32'(used), 32'(q.size()));
    chk({tag, ".empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == 16));
    chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= 14));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_un));
    chk({tag, ".inv"}, 32'(full & fifo_empty), 32'(0));
  endtask

  task automatic drive(input string tag, input bit w, input logic [7:0] d, input bit r);
    wr_en = w; wr_data = d; fifo_req_data = r;
    cycle(tag);
    wr_en = 1'b0; fifo_req_data = 1'b0;
  endtask

  initial begin
    // Reset held two cycles.
    rst = 1'b1;
    cycle("rst0");
    cycle("rst1");
    chk("rst.empty_const", 32'(fifo_empty), 32'(1));
    chk("rst.used_const", 32'(used), 32'(0));
    rst = 1'b0;

    // Three writes, three back-to-back reads.
    drive("w3", 1'b1, 8'h11, 1'b0);
    drive("w3", 1'b1, 8'h22, 1'b0);
    drive("w3", 1'b1, 8'h33, 1'b0);
    drive("r3a", 1'b0, 8'h00, 1'b1);
    chk("r3a.din_const", 32'(fifo_din), 32'h11);
    drive("r3b", 1'b0, 8'h00, 1'b1);
    chk("r3b.din_const", 32'(fifo_din), 32'h22);
    drive("r3c", 1'b0, 8'h00, 1'b1);
    chk("r3c.din_const", 32'(fifo_din), 32'h33);
    chk("r3c.empty_const", 32'(fifo_empty), 32'(1));
    drive("idle", 1'b0, 8'h00, 1'b0);

    // Fill to 16, overflow attempt, then drain.
    for (int i = 0; i < 16; i++) drive("fill", 1'b1, 8'(i), 1'b0);
    chk("fill.full_const", 32'(full), 32'(1));
    drive("ovf", 1'b1, 8'hAA, 1'b0);
    chk("ovf.pulse_const", 32'(overflow), 32'(1));
    for (int i = 0; i < 16; i++) drive("drain", 1'b0, 8'h00, 1'b1);
    drive("idle", 1'b0, 8'h00, 1'b0);

    // Write + read on a full FIFO, then on an empty FIFO.
    for (int i = 0; i < 16; i++) drive("fill2", 1'b1, 8'(8'h40 + i), 1'b0);
    drive("fullrw", 1'b1, 8'h55, 1'b1);
    chk("fullrw.used_const", 32'(used), 32'(16));
    for (int i = 0; i < 16; i++) drive("drain2", 1'b0, 8'h00, 1'b1);
    chk("drain2.last_const", 32'(fifo_din), 32'h55);
    drive("emptyrw", 1'b1, 8'h66, 1'b1);
    chk("emptyrw.unf_const", 32'(underflow), 32'(1));
    drive("emptyrw2", 1'b0, 8'h00, 1'b1);
    drive("idle", 1'b0, 8'h00, 1'b0);

    // Pointer wrap with interleaved traffic.
    for (int i = 0; i < 40; i++) drive("wrap", 1'b1, 8'(i), i > 0);
    drive("wrapend", 1'b0, 8'h00, 1'b1);
    chk("wrapend.din_const", 32'(fifo_din), 32'h27);
    drive("idle", 1'b0, 8'h00, 1'b0);

    // Reset and flush while a read is in flight.
    for (int i = 0; i < 5; i++) drive("pre_rst", 1'b1, 8'(8'h80 + i), 1'b0);
    drive("req_rst", 1'b0, 8'h00, 1'b1);
    rst = 1'b1; fifo_req_data = 1'b1;
    cycle("midrst");
    rst = 1'b0; fifo_req_data = 1'b0;
    chk("midrst.valid_const", 32'(fifo_din_valid), 32'(0));
    for (int i = 0; i < 5; i++) drive("pre_fl", 1'b1, 8'(8'h90 + i), 1'b0);
    drive("req_fl", 1'b0, 8'h00, 1'b1);
    flush = 1'b1; fifo_req_data = 1'b1; wr_en = 1'b1;
    cycle("midflush");
    flush = 1'b0; fifo_req_data = 1'b0; wr_en = 1'b0;
    chk("midflush.used_const", 32'(used), 32'(0));
    drive("idle", 1'b0, 8'h00, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 3);
      wr_en = ($urandom_range(0, 99) < 60);
      fifo_req_data = ($urandom_range(0, 99) < 50);
      wr_data = 8'($urandom);
      cycle("rand");
    end
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; fifo_req_data = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
